// File: rtl/pp_seq_mult_ctrl_pkg.sv
// rtl/pp_seq_mult_ctrl_pkg.sv - shared widths, constants and FSM encodings for the sequential multiplier
package pp_seq_mult_ctrl_pkg;
  localparam int W     = 16;
  localparam int P_W   = 2 * W;
  localparam int CNT_W = $clog2(W);

  // Baugh-Wooley correction: compensates the inverted row MSBs and the sign weight
  localparam logic [P_W-1:0] BW_CONST = (P_W'(1) << W) + (P_W'(1) << (P_W - 1));

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/pp_seq_mult_ctrl_row_gen.sv
// rtl/pp_seq_mult_ctrl_row_gen.sv - one Baugh-Wooley partial-product row (module pp_row_gen)
module pp_row_gen
  import pp_seq_mult_ctrl_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic         b_bit,
  input  logic         row_is_last,
  input  logic         signed_mode,
  output logic [W-1:0] row
);
  always_comb begin
    row = '0;
    for (int j = 0; j < W; j++) begin
      // invert exactly the terms that pair a sign bit with a magnitude bit
      row[j] = (a[j] & b_bit) ^ (signed_mode & ((j == W - 1) ^ row_is_last));
    end
  end
endmodule

// File: rtl/pp_seq_mult_ctrl.sv
// rtl/pp_seq_mult_ctrl.sv - iterative signed/unsigned multiplier, one partial-product row per cycle
module pp_seq_mult_ctrl
  import pp_seq_mult_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_p,
  output logic           busy
);
  logic [1:0]       state;
  logic [P_W-1:0]   acc;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             signed_q;
  logic [W-1:0]     row;
  logic             row_is_last;

  assign row_is_last = (cnt == CNT_W'(W - 1));

  pp_row_gen u_row_gen (
    .a           (a_q),
    .b_bit       (b_q[cnt]),
    .row_is_last (row_is_last),
    .signed_mode (signed_q),
    .row         (row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= in_b;
            signed_q <= in_signed;
            cnt      <= '0;
            acc      <= in_signed ? BW_CONST : '0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc + ({{W{1'b0}}, row} << cnt);
          cnt <= cnt + 1'b1;
          if (row_is_last) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_p     = acc;
endmodule

// File: tb/tb_pp_seq_mult_ctrl.sv
// tb/tb_pp_seq_mult_ctrl.sv - directed and random self-checking bench for pp_seq_mult_ctrl
module tb_pp_seq_mult_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_p;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int prev_accept = 0;

  pp_seq_mult_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(posedge clk);
    accept_cyc = cyc;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp, input bit chk_run);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      if (chk_run) check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd16);
    check({tag, "_p"}, out_p, exp);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] exp);
    start_op(a, b, s);
    wait_done(tag, exp, 1'b1);
    handshake(tag);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    logic [31:0] rexp;

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_p", out_p, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op("s_m1_m1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
    do_op("s_min_min", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    do_op("s_max_min", 16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000);
    do_op("u_ff_ff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    do_op("u_0_1234", 16'h0000, 16'h1234, 1'b0, 32'h0000_0000);

    // backpressure: result held while out_ready is low, in_valid pulses ignored
    start_op(16'd100, 16'd7, 1'b0);
    wait_done("bp", 32'd700, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0]; in_a = 16'h5555; in_b = 16'h3333;
      check("bp_out_p_hold", out_p, 32'd700);
      check("bp_out_valid_hold", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out_p_final", out_p, 32'd700);
    handshake("bp");
    check("bp_busy_after", 32'(busy), 32'd0);

    // asynchronous reset with cnt at 7 mid-RUN
    start_op(16'h1234, 16'h5678, 1'b1);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_p", out_p, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("s_3_m5", 16'd3, 16'hFFFB, 1'b1, 32'hFFFF_FFF1);

    // back-to-back random operands, checked against a behavioural product
    prev_accept = -1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (rs) rexp = 32'($signed(ra) * $signed(rb));
      else    rexp = {16'd0, ra} * {16'd0, rb};
      start_op(ra, rb, rs);
      if (prev_accept >= 0) check("rnd_spacing", 32'(accept_cyc - prev_accept), 32'd18);
      prev_accept = accept_cyc;
      wait_done("rnd", rexp, 1'b0);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pp_seq_mult_ctrl.md
Name: pp_seq_mult_ctrl

Overview:
Iterative controller that sequences the signed partial-product datapath of the 16x16 Dadda multiplier, one row per cycle. It serves low-area paths that cannot afford the full reduction tree. Each accepted operand pair is expanded into Baugh-Wooley partial-product rows: magnitude bits are AND terms and the row MSB is inverted. The rows are accumulated into a 2W-bit product. Valid/ready handshakes on both sides.

Parameters:
W, 16, operand width in bits; product is 2W bits
BW_CONST, (1<<W) + (1<<(2W-1)), Baugh-Wooley correction constant preloaded into the accumulator in signed mode

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
in_a  in  W  multiplicand
in_b  in  W  multiplier
in_signed  in  1  1 = two's-complement operands, 0 = unsigned
out_valid  out  1  product valid
out_ready  in  1  consumer takes product this cycle
out_p  out  2W  product
busy  out  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE). busy = !IDLE. out_valid = (state==DONE).
- Reset (async, any state): state=IDLE, acc=0, cnt=0, latched operands=0.
  - Resulting outputs: in_ready=1, out_valid=0, busy=0, out_p=0.
  - An in-flight operation is discarded with no output.
- IDLE, in_valid at edge T:
  - Latch a, b, signed.
  - cnt<=0.
  - acc<=BW_CONST if signed, else 0.
  - Go to RUN.
- RUN, each edge: acc <= acc + (row(cnt) zero-extended to 2W) << cnt, mod 2^(2W).
  - cnt increments.
  - At cnt==W-1 the last row is added and the state goes to DONE.
  - The product is therefore visible from edge T+W onward: latency W cycles from acceptance to out_valid.
- Row i, bit j, signed mode:
  - i<W-1, j<W-1: a[j]&b[i]
  - i<W-1, j=W-1: ~(a[W-1]&b[i])
  - i=W-1, j<W-1: ~(a[j]&b[W-1])
  - i=W-1, j=W-1: a[W-1]&b[W-1]
- Row i, bit j, unsigned mode: a[j]&b[i], no inversion.
- DONE:
  - out_p = acc, held stable while out_ready=0 (no limit on backpressure).
  - Edge with out_ready=1 → IDLE.
  - in_ready rises the cycle after the handshake, so minimum spacing is W+2 cycles per operation.
- Ignored inputs:
  - in_valid while !IDLE is ignored; the source must hold its operands until in_ready.
  - out_ready while !out_valid has no effect.
- out_p in IDLE/RUN shows acc and is don't-care; checkers sample it only when out_valid=1.
- Correctness requirement: out_p == a*b as 2W-bit signed (signed mode) or unsigned product, for all operand values.

Decomposition:
- Shared package: W, BW_CONST, state enum {IDLE, RUN, DONE}, row-index width $clog2(W).
- One sub-module, pp_row_gen:
  - Inputs: a[W-1:0], b_bit, row_is_last, signed_mode.
  - Output: row[W-1:0].
  - Purely combinational.
  - Implements the inversion rules above; reused by the Dadda front end.

Test Plan:
- Signed -1 x -1 (0xFFFF, 0xFFFF) → out_p=0x0000_0001 after exactly 16 cycles; in_ready low throughout.
- Signed -32768 x -32768 → 0x4000_0000; signed 32767 x -32768 → 0xC000_8000.
- Unsigned 0xFFFF x 0xFFFF → 0xFFFE_0001; unsigned 0 x 0x1234 → 0.
- Backpressure: out_ready low for 5 cycles after out_valid → out_p stable, in_valid pulses ignored; a later handshake returns to IDLE and in_ready=1 on the next cycle.
- Reset asserted mid-RUN (cnt=7) → all outputs at reset values immediately. After release, operands 3 x -5 signed → 0xFFFF_FFF1.
- Back-to-back: 1000 random signed/unsigned pairs with out_ready held high → every result matches the reference model; spacing 18 cycles.
